cpu_fetch: RTL and testbench

Instruction fetch stage. It sits directly upstream of the decode/execute stage. It reads one 3-word instruction (opcode, operand A, operand B) from instruction memory at the current PC and presents it to decode/execute with a `fetch_done_o` pulse. It then waits for `exec_done_i` and advances the PC: sequentially by `FETCH_STEP_SIZE`, or to the jump target when execute reports a taken jump.

---
 rtl/cpu_fetch_pkg.sv | 18 +
 rtl/cpu_fetch_pc.sv | 50 +++++
 rtl/cpu_fetch.sv | 135 +++++++++++++
 tb/tb_cpu_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared fetch constants and state encoding for cpu_fetch and downstream decode/execute.
package cpu_fetch_pkg;

    localparam logic [31:0] FETCH_STEP_SIZE = 32'hC;
    localparam logic [7:0]  OPCODE_INIT     = 8'hFF;
    localparam logic [31:0] WORD_BYTES      = 32'h4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ_OP    = 3'd1,
        ST_REQ_A     = 3'd2,
        ST_REQ_B     = 3'd3,
        ST_DONE      = 3'd4,
        ST_WAIT_EXEC = 3'd5,
        ST_HALT      = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/cpu_fetch_pc.sv
// Program counter for the fetch stage: next-pc selection, jump-target alignment check, sticky error.
module cpu_fetch_pc
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             accept_i,
    input  logic             isjcc_i,
    input  logic [WIDTH-1:0] newpc_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] next_pc_o,
    output logic             misalign_o,
    output logic             err_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             err_q, err_d;

    always_comb begin
        misalign_o = isjcc_i && (newpc_i[1:0] != 2'b00);
        next_pc_o  = isjcc_i ? newpc_i : pc_q + WIDTH'(FETCH_STEP_SIZE);
        pc_d       = pc_q;
        err_d      = err_q;
        // A misaligned target never reaches the pc; it only raises the flag.
        if (accept_i) begin
            if (misalign_o) begin
                err_d = 1'b1;
            end else begin
                pc_d = next_pc_o;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc_o  = pc_q;
    assign err_o = err_q;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: reads opcode/opA/opB at pc, hands them to execute, then advances pc.
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    input  logic             mem_ack_i,
    output logic [WIDTH-1:0] opcode_o,
    output logic [WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0] opb_o,
    output logic             fetch_done_o,
    input  logic             exec_done_i,
    input  logic             isjcc_i,
    input  logic [WIDTH-1:0] newpc_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             fetch_err_o
);

    fetch_state_e     state_q;
    logic             mem_req_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic             done_q;
    logic [WIDTH-1:0] opcode_q, opa_q, opb_q;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_pc;
    logic             misalign;
    logic             accept;
    logic             ack;

    // DONE is excluded so a level held high through the pulse is not taken early.
    assign accept = (state_q == ST_WAIT_EXEC) && exec_done_i;
    assign ack    = mem_req_q && mem_ack_i;

    cpu_fetch_pc #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .accept_i   (accept),
        .isjcc_i    (isjcc_i),
        .newpc_i    (newpc_i),
        .pc_o       (pc),
        .next_pc_o  (next_pc),
        .misalign_o (misalign),
        .err_o      (fetch_err_o)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            done_q     <= 1'b0;
            opcode_q   <= WIDTH'(OPCODE_INIT);
            opa_q      <= '0;
            opb_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q    <= ST_REQ_OP;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc;
                    end
                end
                ST_REQ_OP: begin
                    if (ack) begin
                        opcode_q   <= mem_rdata_i;
                        state_q    <= ST_REQ_A;
                        mem_addr_q <= pc + WIDTH'(WORD_BYTES);
                    end
                end
                ST_REQ_A: begin
                    if (ack) begin
                        opa_q      <= mem_rdata_i;
                        state_q    <= ST_REQ_B;
                        mem_addr_q <= pc + WIDTH'(2 * WORD_BYTES);
                    end
                end
                ST_REQ_B: begin
                    if (ack) begin
                        opb_q     <= mem_rdata_i;
                        state_q   <= ST_DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_WAIT_EXEC;
                end
                ST_WAIT_EXEC: begin
                    if (exec_done_i) begin
                        if (misalign) begin
                            state_q <= ST_HALT;
                        end else begin
                            mem_addr_q <= next_pc;
                            if (enable_i) begin
                                state_q   <= ST_REQ_OP;
                                mem_req_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    mem_req_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign fetch_done_o = done_q;
    assign opcode_o     = opcode_q;
    assign opa_o        = opa_q;
    assign opb_o        = opb_q;
    assign pc_o         = pc;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch with a small wait-state-capable instruction memory model.
module tb_cpu_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        enable_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [31:0] opcode_o, opa_o, opb_o;
    logic        fetch_done_o;
    logic        exec_done_i;
    logic        isjcc_i;
    logic [31:0] newpc_i;
    logic [31:0] pc_o;
    logic        fetch_err_o;

    int checks = 0;
    int errors = 0;

    int unsigned wait_cfg = 0;
    int unsigned wcnt = 0;

    always #5 clk_i = ~clk_i;

    cpu_fetch #(
        .WIDTH    (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .enable_i     (enable_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .opcode_o     (opcode_o),
        .opa_o        (opa_o),
        .opb_o        (opb_o),
        .fetch_done_o (fetch_done_o),
        .exec_done_i  (exec_done_i),
        .isjcc_i      (isjcc_i),
        .newpc_i      (newpc_i),
        .pc_o         (pc_o),
        .fetch_err_o  (fetch_err_o)
    );

    // Words at 0/4/8 hold {0x00,5,7}; every other address returns addr ^ 0xA5A50000.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0;
            32'h4:   return 32'h5;
            32'h8:   return 32'h7;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    always @(posedge clk_i) begin
        if (!mem_req_o || mem_ack_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    assign mem_ack_i   = mem_req_o && (wcnt >= wait_cfg);
    assign mem_rdata_i = mem_ack_i ? memf(mem_addr_o) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; enable_i = 1'b0; exec_done_i = 1'b0; isjcc_i = 1'b0; newpc_i = '0;
        tick(); tick();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", mem_addr_o); end
        checks++; if (fetch_done_o !== 1'b0 || fetch_err_o !== 1'b0) begin errors++; $display("FAIL rst_flags got done=%b err=%b want 0 0", fetch_done_o, fetch_err_o); end
        checks++; if (opcode_o !== 32'hFF) begin errors++; $display("FAIL rst_opcode got %h want 000000ff", opcode_o); end
        checks++; if (opa_o !== 32'h0 || opb_o !== 32'h0) begin errors++; $display("FAIL rst_ops got %h %h want 0 0", opa_o, opb_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc_o); end
        rst_n_i = 1'b1;
        tick();
    endtask

    // Cycle 0 = enable seen in IDLE; requests at 1..3, pulse at 4.
    task automatic test_first_fetch();
        enable_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(4 * (k - 1))) begin
                errors++; $display("FAIL first_req%0d got req=%b addr=%h want 1 %h", k, mem_req_o, mem_addr_o, 32'(4 * (k - 1)));
            end
        end
        tick();
        checks++; if (fetch_done_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL first_done got done=%b req=%b want 1 0", fetch_done_o, mem_req_o); end
        checks++; if (opcode_o !== 32'h0 || opa_o !== 32'h5 || opb_o !== 32'h7) begin errors++; $display("FAIL first_ops got %h %h %h want 0 5 7", opcode_o, opa_o, opb_o); end
        tick();
        checks++; if (fetch_done_o !== 1'b0) begin errors++; $display("FAIL first_pulse_width got %b want 0", fetch_done_o); end
    endtask

    task automatic run_fetch(input logic [31:0] base, input string name);
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (mem_addr_o !== base + 32'(4 * k)) begin errors++; $display("FAIL %s_addr%0d got %h want %h", name, k, mem_addr_o, base + 32'(4 * k)); end
        end
        tick();
        checks++;
        if (fetch_done_o !== 1'b1 || opcode_o !== memf(base) || opb_o !== memf(base + 32'h8)) begin
            errors++; $display("FAIL %s_done got done=%b op=%h opb=%h want 1 %h %h", name, fetch_done_o, opcode_o, opb_o, memf(base), memf(base + 32'h8));
        end
        tick();
    endtask

    task automatic test_sequential();
        exec_done_i = 1'b1; isjcc_i = 1'b0;
        tick();
        exec_done_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hC || pc_o !== 32'hC) begin errors++; $display("FAIL seq_start got req=%b addr=%h pc=%h want 1 c c", mem_req_o, mem_addr_o, pc_o); end
        run_fetch(32'hC, "seq");
    endtask

    task automatic test_jump();
        exec_done_i = 1'b1; isjcc_i = 1'b1; newpc_i = 32'h30;
        tick();
        exec_done_i = 1'b0; isjcc_i = 1'b0;
        checks++; if (mem_addr_o !== 32'h30 || pc_o !== 32'h30) begin errors++; $display("FAIL jump_start got addr=%h pc=%h want 30 30", mem_addr_o, pc_o); end
        run_fetch(32'h30, "jump");
    endtask

    // 3 wait cycles per word: pulse at cycle 13; enable dropped mid-fetch must not stop it.
    task automatic test_wait_states();
        logic [31:0] exp_addr;
        int unsigned done_cyc = 0;
        logic        addr_ok = 1'b1;
        enable_i = 1'b0; exec_done_i = 1'b1;
        tick();
        exec_done_i = 1'b0;
        checks++; if (mem_req_o !== 1'b0 || pc_o !== 32'h3C) begin errors++; $display("FAIL park_idle got req=%b pc=%h want 0 3c", mem_req_o, pc_o); end
        tick();
        wait_cfg = 3; enable_i = 1'b1;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            tick();
            if (c == 6) enable_i = 1'b0;
            if (fetch_done_o === 1'b1) done_cyc = c;
            else if (c <= 12) begin
                exp_addr = 32'h3C + 32'(4 * ((c - 1) / 4));
                if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr) addr_ok = 1'b0;
            end
        end
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL ws_addr_stable got %b want 1", addr_ok); end
        checks++; if (done_cyc != 13) begin errors++; $display("FAIL ws_done_cycle got %0d want 13", done_cyc); end
        checks++; if (opcode_o !== 32'hA5A5003C || opa_o !== 32'hA5A50040 || opb_o !== 32'hA5A50044) begin errors++; $display("FAIL ws_ops got %h %h %h want a5a5003c a5a50040 a5a50044", opcode_o, opa_o, opb_o); end
        wait_cfg = 0;
        tick();
    endtask

    task automatic test_exec_stuck();
        enable_i = 1'b1; exec_done_i = 1'b1; isjcc_i = 1'b0;
        tick();
        checks++; if (mem_addr_o !== 32'h48) begin errors++; $display("FAIL stuck_start got %h want 48", mem_addr_o); end
        tick(); tick(); tick();
        checks++; if (fetch_done_o !== 1'b1 || pc_o !== 32'h48) begin errors++; $display("FAIL stuck_done got done=%b pc=%h want 1 48", fetch_done_o, pc_o); end
        tick();
        checks++; if (pc_o !== 32'h48 || mem_req_o !== 1'b0) begin errors++; $display("FAIL stuck_no_early got pc=%h req=%b want 48 0", pc_o, mem_req_o); end
        tick();
        checks++; if (pc_o !== 32'h54 || mem_addr_o !== 32'h54 || mem_req_o !== 1'b1) begin errors++; $display("FAIL stuck_accept got pc=%h addr=%h req=%b want 54 54 1", pc_o, mem_addr_o, mem_req_o); end
        tick(); tick(); tick();
        checks++; if (fetch_done_o !== 1'b1) begin errors++; $display("FAIL stuck_second_done got %b want 1", fetch_done_o); end
        exec_done_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_and_wrap();
        logic saw_pulse = 1'b0;
        exec_done_i = 1'b1;
        tick();
        exec_done_i = 1'b0;
        tick();
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h64) begin errors++; $display("FAIL mid_req_a got req=%b addr=%h want 1 64", mem_req_o, mem_addr_o); end
        #2 rst_n_i = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b0 || opcode_o !== 32'hFF || pc_o !== 32'h0 || mem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_async got req=%b op=%h pc=%h addr=%h want 0 ff 0 0", mem_req_o, opcode_o, pc_o, mem_addr_o); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (fetch_done_o !== 1'b0) saw_pulse = 1'b1;
        end
        checks++; if (saw_pulse !== 1'b0) begin errors++; $display("FAIL mid_no_pulse got %b want 0", saw_pulse); end
        rst_n_i = 1'b1;
        tick();
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_restart got req=%b addr=%h want 1 0", mem_req_o, mem_addr_o); end
        run_fetch(32'h0, "restart");
        exec_done_i = 1'b1; isjcc_i = 1'b1; newpc_i = 32'hFFFF_FFF4;
        tick();
        exec_done_i = 1'b0; isjcc_i = 1'b0;
        checks++; if (pc_o !== 32'hFFFF_FFF4) begin errors++; $display("FAIL wrap_jump got %h want fffffff4", pc_o); end
        run_fetch(32'hFFFF_FFF4, "top");
        exec_done_i = 1'b1;
        tick();
        exec_done_i = 1'b0;
        checks++; if (pc_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_req_o !== 1'b1) begin errors++; $display("FAIL wrap_seq got pc=%h addr=%h req=%b want 0 0 1", pc_o, mem_addr_o, mem_req_o); end
        run_fetch(32'h0, "wrapped");
    endtask

    task automatic test_misaligned();
        logic saw_req = 1'b0;
        exec_done_i = 1'b1; isjcc_i = 1'b1; newpc_i = 32'h31;
        tick();
        exec_done_i = 1'b0; isjcc_i = 1'b0;
        checks++; if (fetch_err_o !== 1'b1 || pc_o !== 32'h0 || mem_req_o !== 1'b0) begin errors++; $display("FAIL misalign got err=%b pc=%h req=%b want 1 0 0", fetch_err_o, pc_o, mem_req_o); end
        enable_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 3) exec_done_i = 1'b1;
            if (mem_req_o !== 1'b0) saw_req = 1'b1;
        end
        checks++; if (saw_req !== 1'b0 || fetch_err_o !== 1'b1) begin errors++; $display("FAIL halt_stays got req_seen=%b err=%b want 0 1", saw_req, fetch_err_o); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_jump();
        test_wait_states();
        test_exec_stuck();
        test_reset_mid_and_wrap();
        test_misaligned();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
